// File: rtl/fifo_tx_drain_ctrl.sv
// Read-side sequencer: pops one FIFO byte per frame and hands it to the UART TX with a load strobe.
// Latency: FIFO non-empty (EN=1, TX idle) to R_INC 1 cycle; R_INC to TX_DATA_VALID 1 cycle.
// Backpressure: no pop while TX_BUSY is high or EN is low; each frame is followed by a GAP_CYCLES+1 cycle gap.
module fifo_tx_drain_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int GAP_CYCLES   = 2,
    parameter int BUSY_TIMEOUT = 16,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  r_inc,
    input  logic                  tx_busy,
    output logic [DATA_WIDTH-1:0] tx_p_data,
    output logic                  tx_data_valid,
    input  logic                  err_clr,
    output logic                  active,
    output logic [CNT_WIDTH-1:0]  byte_cnt,
    output logic                  to_err
);

    localparam int TO_W  = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(BUSY_TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_LOAD,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [TO_W-1:0]        to_cnt;
    logic [TO_W-1:0]        to_cnt_nxt;
    logic [GAP_W-1:0]       gap_cnt;
    logic [GAP_W-1:0]       gap_cnt_nxt;
    logic [DATA_WIDTH-1:0]  tx_p_data_nxt;
    logic [CNT_WIDTH-1:0]   byte_cnt_nxt;
    logic                   to_err_nxt;

    always_comb begin
        state_nxt     = state;
        to_cnt_nxt    = to_cnt;
        gap_cnt_nxt   = gap_cnt;
        tx_p_data_nxt = tx_p_data;
        byte_cnt_nxt  = byte_cnt;
        // A timeout raised in the same cycle as a clear overrides the clear below.
        to_err_nxt    = to_err & ~err_clr;

        case (state)
            S_IDLE: begin
                if (en && !fifo_empty && !tx_busy) begin
                    state_nxt = S_POP;
                end
            end
            S_POP: begin
                tx_p_data_nxt = rd_data;
                state_nxt     = S_LOAD;
            end
            S_LOAD: begin
                to_cnt_nxt = '0;
                state_nxt  = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_nxt = S_WAIT_DONE;
                end else if (to_cnt == TO_LAST) begin
                    to_err_nxt  = 1'b1;
                    gap_cnt_nxt = GAP_LOAD;
                    state_nxt   = S_GAP;
                end else begin
                    to_cnt_nxt = to_cnt + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    byte_cnt_nxt = byte_cnt + 1'b1;
                    gap_cnt_nxt  = GAP_LOAD;
                    state_nxt    = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = S_IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Strobes and ACTIVE are decoded from the next state so they align with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            to_cnt        <= '0;
            gap_cnt       <= '0;
            tx_p_data     <= '0;
            byte_cnt      <= '0;
            to_err        <= 1'b0;
            r_inc         <= 1'b0;
            tx_data_valid <= 1'b0;
            active        <= 1'b0;
        end else begin
            state         <= state_nxt;
            to_cnt        <= to_cnt_nxt;
            gap_cnt       <= gap_cnt_nxt;
            tx_p_data     <= tx_p_data_nxt;
            byte_cnt      <= byte_cnt_nxt;
            to_err        <= to_err_nxt;
            r_inc         <= (state_nxt == S_POP);
            tx_data_valid <= (state_nxt == S_LOAD);
            active        <= (state_nxt != S_IDLE);
        end
    end

endmodule

// File: tb/tb_fifo_tx_drain_ctrl.sv
// Bench for fifo_tx_drain_ctrl: queue-based FIFO and UART TX models, frame vector table,
// directed corner sequences and a randomized phase checked against a transaction-level model.
module tb_fifo_tx_drain_ctrl;

    localparam int DW  = 8;
    localparam int GAP = 2;
    localparam int TO  = 16;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] rd_data = '0;
    logic          r_inc;
    logic          tx_busy = 1'b0;
    logic [DW-1:0] tx_p_data;
    logic          tx_data_valid;
    logic          err_clr = 1'b0;
    logic          active;
    logic [CW-1:0] byte_cnt;
    logic          to_err;

    fifo_tx_drain_ctrl #(
        .DATA_WIDTH  (DW),
        .GAP_CYCLES  (GAP),
        .BUSY_TIMEOUT(TO),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .fifo_empty   (fifo_empty),
        .rd_data      (rd_data),
        .r_inc        (r_inc),
        .tx_busy      (tx_busy),
        .tx_p_data    (tx_p_data),
        .tx_data_valid(tx_data_valid),
        .err_clr      (err_clr),
        .active       (active),
        .byte_cnt     (byte_cnt),
        .to_err       (to_err)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    // Environment state shared between the model process and the test sequence.
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] popped_q[$];
    logic [DW-1:0] got_q[$];
    int  busy_len = 10;
    bit  tx_hang = 1'b0;
    bit  tx_ext = 1'b0;
    int  busy_left = 0;
    bit  go = 1'b0;
    int  go_len = 0;
    bit  pop_pend = 1'b0;
    int  cyc = 0;
    int  last_rinc_cyc = 0;
    int  last_min = 0;
    bit  have_last = 1'b0;
    bit  prev_rinc = 1'b0;
    bit  prev_vld = 1'b0;
    int  rinc_cnt = 0;
    int  valid_cnt = 0;
    int  ok_frames = 0;
    int  hang_frames = 0;

    typedef struct {
        int data;
        int blen;
        bit hang;
        int exp_cnt;
        int exp_err;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input string nm, input int bound);
        int n = 0;
        while (!tx_data_valid && n < bound) begin
            tick();
            n++;
        end
        chk(nm, 32'(tx_data_valid), 1);
    endtask

    task automatic wait_rinc(input string nm, input int bound);
        int n = 0;
        while (!r_inc && n < bound) begin
            tick();
            n++;
        end
        chk(nm, 32'(r_inc), 1);
    endtask

    // need_empty also waits for the FIFO model to drain.
    task automatic wait_idle(input string nm, input int bound, input bit need_empty);
        int n = 0;
        while ((active || (need_empty && (fifo_q.size() != 0 || pop_pend))) && n < bound) begin
            tick();
            n++;
        end
        chk(nm, 32'(active), 0);
    endtask

    // FIFO and UART TX models plus per-event protocol checks, sampled 1 ns after each edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (pop_pend) begin
            if (fifo_q.size() > 0) popped_q.push_back(fifo_q.pop_front());
            pop_pend = 1'b0;
        end
        if (rst) begin
            popped_q.delete();
            busy_left = 0;
            go        = 1'b0;
            have_last = 1'b0;
            prev_rinc = 1'b0;
            prev_vld  = 1'b0;
        end else begin
            if (r_inc) begin
                chk("rinc_while_empty", 32'(fifo_empty), 0);
                chk("rinc_one_cycle", 32'(prev_rinc), 0);
                if (have_last)
                    chk("rinc_spacing", 32'((cyc - last_rinc_cyc) >= last_min), 1);
                last_rinc_cyc = cyc;
                have_last     = 1'b1;
                pop_pend      = 1'b1;
                rinc_cnt++;
            end
            if (tx_data_valid) begin
                chk("vld_one_cycle", 32'(prev_vld), 0);
                chk("vld_after_pop", 32'(popped_q.size()), 1);
                if (popped_q.size() > 0)
                    chk("vld_byte_order", 32'(tx_p_data), 32'(popped_q.pop_front()));
                got_q.push_back(tx_p_data);
                valid_cnt++;
                if (tx_hang) begin
                    hang_frames++;
                    last_min = TO + GAP + 4;
                end else begin
                    ok_frames++;
                    last_min = busy_len + GAP + 5;
                end
            end
            if (busy_left > 0) busy_left--;
            if (go) busy_left = go_len;
            go        = tx_data_valid && !tx_hang;
            go_len    = busy_len;
            prev_rinc = r_inc;
            prev_vld  = tx_data_valid;
        end
        tx_busy    = (busy_left != 0) || tx_ext;
        fifo_empty = (fifo_q.size() == 0);
        rd_data    = fifo_empty ? '0 : fifo_q[0];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int v0;
        tbl[0] = '{data: 'h3C, blen: 4,  hang: 1'b0, exp_cnt: 4, exp_err: 0};
        tbl[1] = '{data: 'hC3, blen: 1,  hang: 1'b0, exp_cnt: 5, exp_err: 0};
        tbl[2] = '{data: 'h7E, blen: 1,  hang: 1'b1, exp_cnt: 5, exp_err: 1};
        tbl[3] = '{data: 'h81, blen: 6,  hang: 1'b0, exp_cnt: 6, exp_err: 1};
        tbl[4] = '{data: 'hFF, blen: 15, hang: 1'b0, exp_cnt: 7, exp_err: 1};
        tbl[5] = '{data: 'h00, blen: 2,  hang: 1'b0, exp_cnt: 8, exp_err: 1};

        // Reset values.
        repeat (3) tick();
        chk("rst_r_inc", 32'(r_inc), 0);
        chk("rst_valid", 32'(tx_data_valid), 0);
        chk("rst_p_data", 32'(tx_p_data), 0);
        chk("rst_active", 32'(active), 0);
        chk("rst_byte_cnt", 32'(byte_cnt), 0);
        chk("rst_to_err", 32'(to_err), 0);
        rst = 1'b0;
        tick();

        // Single byte: exact pop/load latency and gap length.
        en = 1'b1;
        busy_len = 10;
        fifo_q.push_back(8'hA5);
        tick();
        chk("single_empty_fell", 32'(fifo_empty), 0);
        chk("single_no_rinc_yet", 32'(r_inc), 0);
        tick();
        chk("single_rinc", 32'(r_inc), 1);
        chk("single_active", 32'(active), 1);
        tick();
        chk("single_valid", 32'(tx_data_valid), 1);
        chk("single_data", 32'(tx_p_data), 32'hA5);
        chk("single_rinc_low", 32'(r_inc), 0);
        tick();
        chk("single_valid_low", 32'(tx_data_valid), 0);
        begin
            int n = 0;
            while (byte_cnt != 1 && n < 50) begin
                tick();
                n++;
            end
        end
        chk("single_cnt", 32'(byte_cnt), 1);
        chk("single_busy_fell", 32'(tx_busy), 0);
        chk("single_data_held", 32'(tx_p_data), 32'hA5);
        tick();
        chk("single_gap1", 32'(active), 1);
        tick();
        chk("single_gap2", 32'(active), 1);
        tick();
        chk("single_active_drop", 32'(active), 0);

        // Reset while in POP: popped byte is dropped.
        fifo_q.push_back(8'h5A);
        wait_rinc("rstpop_wait_rinc", 50);
        rst = 1'b1;
        tick();
        chk("rstpop_r_inc", 32'(r_inc), 0);
        chk("rstpop_valid", 32'(tx_data_valid), 0);
        chk("rstpop_active", 32'(active), 0);
        chk("rstpop_cnt", 32'(byte_cnt), 0);
        chk("rstpop_to_err", 32'(to_err), 0);
        chk("rstpop_p_data", 32'(tx_p_data), 0);
        tick();
        rst = 1'b0;
        v0 = valid_cnt;
        repeat (15) tick();
        chk("rstpop_no_valid", 32'(valid_cnt - v0), 0);
        chk("rstpop_byte_gone", 32'(fifo_q.size()), 0);

        // Burst of three bytes, then idle on an empty FIFO.
        got_q.delete();
        r0 = rinc_cnt;
        fifo_q.push_back(8'h01);
        fifo_q.push_back(8'h02);
        fifo_q.push_back(8'h03);
        wait_idle("burst_done", 200, 1'b1);
        chk("burst_rinc_cnt", 32'(rinc_cnt - r0), 3);
        chk("burst_got_n", 32'(got_q.size()), 3);
        for (int i = 0; i < 3 && i < got_q.size(); i++)
            chk($sformatf("burst_byte%0d", i), 32'(got_q[i]), 32'(i + 1));
        chk("burst_cnt", 32'(byte_cnt), 3);
        repeat (20) tick();
        chk("burst_no_rinc_empty", 32'(rinc_cnt - r0), 3);

        // Frame vector table: data, busy length, timeout and resulting counters.
        for (int i = 0; i < 6; i++) begin
            busy_len = tbl[i].blen;
            tx_hang  = tbl[i].hang;
            fifo_q.push_back(8'(tbl[i].data));
            wait_valid($sformatf("tbl%0d_vld", i), 50);
            chk($sformatf("tbl%0d_data", i), 32'(tx_p_data), 32'(tbl[i].data));
            wait_idle($sformatf("tbl%0d_idle", i), 80, 1'b1);
            chk($sformatf("tbl%0d_cnt", i), 32'(byte_cnt), 32'(tbl[i].exp_cnt));
            chk($sformatf("tbl%0d_err", i), 32'(to_err), 32'(tbl[i].exp_err));
            tx_hang = 1'b0;
        end

        // Exact timeout instant; clear coinciding with set keeps the flag, next clear drops it.
        err_clr = 1'b1;
        tick();
        chk("clr_to_err", 32'(to_err), 0);
        err_clr = 1'b0;
        tx_hang = 1'b1;
        fifo_q.push_back(8'h55);
        wait_valid("to_vld", 50);
        repeat (16) tick();
        chk("to_not_yet", 32'(to_err), 0);
        err_clr = 1'b1;
        tick();
        chk("to_set_wins", 32'(to_err), 1);
        chk("to_cnt_same", 32'(byte_cnt), 8);
        chk("to_in_gap", 32'(active), 1);
        tick();
        chk("to_cleared", 32'(to_err), 0);
        err_clr = 1'b0;
        tx_hang = 1'b0;
        wait_idle("to_idle", 50, 1'b1);

        // EN dropped during WAIT_DONE with two bytes still queued.
        busy_len = 8;
        r0 = rinc_cnt;
        fifo_q.push_back(8'h11);
        fifo_q.push_back(8'h22);
        fifo_q.push_back(8'h33);
        wait_valid("endrop_vld", 50);
        repeat (3) tick();
        en = 1'b0;
        wait_idle("endrop_frame_done", 50, 1'b0);
        chk("endrop_cnt", 32'(byte_cnt), 9);
        repeat (30) tick();
        chk("endrop_no_rinc", 32'(rinc_cnt - r0), 1);
        chk("endrop_queued", 32'(fifo_q.size()), 2);
        en = 1'b1;
        wait_idle("endrop_resume", 200, 1'b1);
        chk("endrop_cnt_final", 32'(byte_cnt), 11);

        // TX busy from elsewhere while idle blocks the pop.
        tx_ext = 1'b1;
        r0 = rinc_cnt;
        fifo_q.push_back(8'h99);
        repeat (20) tick();
        chk("ext_busy_no_rinc", 32'(rinc_cnt - r0), 0);
        tx_ext = 1'b0;
        wait_valid("ext_busy_vld", 50);
        chk("ext_busy_data", 32'(tx_p_data), 32'h99);
        wait_idle("ext_busy_idle", 50, 1'b1);
        chk("ext_busy_cnt", 32'(byte_cnt), 12);

        // Counter wrap: 17 frames on a 4-bit counter.
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        chk("wrap_rst_cnt", 32'(byte_cnt), 0);
        busy_len = 1;
        v0 = valid_cnt;
        for (int i = 0; i < 17; i++) fifo_q.push_back(8'($urandom));
        wait_idle("wrap_done", 1000, 1'b1);
        chk("wrap_frames", 32'(valid_cnt - v0), 17);
        chk("wrap_cnt", 32'(byte_cnt), 1);

        // Randomized traffic, EN toggling, busy lengths and occasional hung transmitter.
        ok_frames   = 0;
        hang_frames = 0;
        r0 = rinc_cnt;
        v0 = valid_cnt;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 5) == 0 && fifo_q.size() < 6) fifo_q.push_back(8'($urandom));
            if (!active && $urandom_range(0, 9) == 0) begin
                busy_len = $urandom_range(1, 12);
                tx_hang  = ($urandom_range(0, 7) == 0);
            end
            if ($urandom_range(0, 19) == 0) en = ~en;
            tick();
        end
        en      = 1'b1;
        tx_hang = 1'b0;
        wait_idle("rand_drain", 3000, 1'b1);
        chk("rand_some_frames", 32'(ok_frames > 0), 1);
        chk("rand_vld_eq_rinc", 32'(valid_cnt - v0), 32'(rinc_cnt - r0));
        chk("rand_cnt", 32'(byte_cnt), 32'((1 + ok_frames) % 16));
        chk("rand_to_err", 32'(to_err), 32'(hang_frames != 0));
        chk("rand_no_stray_pop", 32'(popped_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/fifo_tx_drain_ctrl.md
Name: fifo_tx_drain_ctrl

Overview:
- Read-side sequencer for the async FIFO. Runs in the FIFO read-clock domain, which is also the UART TX clock domain.
- Pops one byte at a time when data is available and the transmitter is idle.
- Presents each byte to the UART transmitter with a one-cycle valid strobe, tracks the frame through the TX busy handshake, and enforces an optional inter-frame gap.
- Provides a transmitted-byte counter and a sticky handshake-timeout flag for the register file.

Parameters:
DATA_WIDTH, 8, width of the FIFO read data and the TX parallel data
GAP_CYCLES, 2, idle clocks inserted after each completed frame (0 = no gap)
BUSY_TIMEOUT, 16, max clocks to wait for TX_BUSY to rise after TX_DATA_VALID
CNT_WIDTH, 16, width of BYTE_CNT

Ports:
CLK  input  1  read/TX domain clock
RST  input  1  synchronous, active-high reset
EN  input  1  drain enable (from register file)
FIFO_EMPTY  input  1  high when FIFO holds no data (read-domain view)
RD_DATA  input  DATA_WIDTH  FIFO head data; valid whenever FIFO_EMPTY=0
R_INC  output  1  one-cycle FIFO pop strobe
TX_BUSY  input  1  UART TX frame in progress
TX_P_DATA  output  DATA_WIDTH  registered byte to transmit
TX_DATA_VALID  output  1  one-cycle load strobe to UART TX
ERR_CLR  input  1  clears TO_ERR
ACTIVE  output  1  high in any state other than IDLE
BYTE_CNT  output  CNT_WIDTH  count of frames completed, wraps
TO_ERR  output  1  sticky busy-handshake timeout flag

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (RST). All state is updated on the CLK rising edge.
- Reset values: state=IDLE; R_INC=0; TX_DATA_VALID=0; TX_P_DATA=0; ACTIVE=0; BYTE_CNT=0; TO_ERR=0; all internal counters=0.
- Reset mid-operation: everything returns to reset values at the next edge. A byte already popped is dropped and is not re-presented.
- All outputs are registered.
- State machine:
  - IDLE: go to POP if EN=1, FIFO_EMPTY=0 and TX_BUSY=0. Otherwise stay in IDLE.
  - POP: R_INC=1 for exactly this one cycle. TX_P_DATA<=RD_DATA is captured on the same edge that leaves POP. Next state is LOAD.
  - LOAD: TX_DATA_VALID=1 for exactly one cycle. TX_P_DATA is held stable until the controller next enters POP. Timeout counter cleared. Next state is WAIT_BUSY.
  - WAIT_BUSY: go to WAIT_DONE when TX_BUSY=1. Otherwise increment the timeout counter. When the counter reaches BUSY_TIMEOUT-1 with TX_BUSY still 0, set TO_ERR=1 and go to GAP; BYTE_CNT is not incremented.
  - WAIT_DONE: on TX_BUSY=0, BYTE_CNT<=BYTE_CNT+1 (modulo 2^CNT_WIDTH) and go to GAP.
  - GAP: load the gap counter on entry and count GAP_CYCLES clocks, then go to IDLE. With GAP_CYCLES=0, GAP lasts exactly one cycle.
- Latency:
  - FIFO_EMPTY falling (with EN=1, TX idle) to R_INC is 1 cycle.
  - R_INC to TX_DATA_VALID is 1 cycle.
- Frame spacing: at most one R_INC per frame. With TX_BUSY asserted 1 cycle after TX_DATA_VALID, consecutive R_INC pulses are separated by (frame busy length + GAP_CYCLES + 5) cycles or more.
- FIFO empty: R_INC is never asserted while FIFO_EMPTY=1. FIFO_EMPTY is sampled only in IDLE.
- EN deasserted mid-frame: the current byte completes normally (through GAP). The controller then stays in IDLE while EN=0.
- TX_BUSY already high in IDLE (frame sourced elsewhere): no pop until it drops.
- TO_ERR: sticky. ERR_CLR=1 clears it at the next edge. If the timeout set and ERR_CLR occur in the same cycle, set wins.
- ACTIVE = (state != IDLE), registered with the state.

Test Plan:
- Reset: RST=1 for 2 cycles during POP → next edge R_INC=0, TX_DATA_VALID=0, BYTE_CNT=0, TO_ERR=0, state IDLE.
- Single byte, GAP_CYCLES=2: FIFO holds 0xA5, EN=1; TX model raises TX_BUSY 1 cycle after valid and holds it 10 cycles →
  - R_INC pulse, then TX_P_DATA=0xA5 with TX_DATA_VALID one cycle later;
  - BYTE_CNT=1 when TX_BUSY falls;
  - ACTIVE drops 3 cycles after that.
- Burst with empty boundary: write 0x01,0x02,0x03 →
  - exactly 3 R_INC pulses, bytes delivered in order, BYTE_CNT=3;
  - no R_INC while FIFO_EMPTY=1 afterwards.
- Timeout, BUSY_TIMEOUT=16: TX_BUSY held 0 after valid →
  - TO_ERR=1 after 16 WAIT_BUSY cycles, BYTE_CNT unchanged, next byte still drained;
  - ERR_CLR=1 clears TO_ERR next edge.
- EN drop mid-frame: EN=0 during WAIT_DONE with 2 bytes queued → current frame completes (BYTE_CNT+1); no further R_INC until EN=1.
- Counter wrap, CNT_WIDTH=4: 17 frames → BYTE_CNT reads 0x1.
